// File: rtl/risc16_pkg.sv
// risc16_pkg: shared definitions for the 16-bit RISC control path.
//   - opcode field values (IR[15:12])
//   - ALU operation select encodings
//   - sequencer state encoding and instruction-class enum
//   - classify(): maps a raw opcode onto its instruction class
package risc16_pkg;

  localparam logic [3:0] OP_LD        = 4'h0;
  localparam logic [3:0] OP_ST        = 4'h1;
  localparam logic [3:0] OP_ALU_FIRST = 4'h2;
  localparam logic [3:0] OP_ALU_LAST  = 4'h9;
  localparam logic [3:0] OP_BEQ       = 4'hB;
  localparam logic [3:0] OP_BNE       = 4'hC;
  localparam logic [3:0] OP_JMP       = 4'hD;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    C_LD      = 3'd0,
    C_ST      = 3'd1,
    C_RTYPE   = 3'd2,
    C_BEQ     = 3'd3,
    C_BNE     = 3'd4,
    C_JMP     = 3'd5,
    C_ILLEGAL = 3'd6
  } op_class_t;

  // 1010 and 1110/1111 fall through to C_ILLEGAL.
  function automatic op_class_t classify(input logic [3:0] op);
    op_class_t c;
    if (op == OP_LD)                                    c = C_LD;
    else if (op == OP_ST)                               c = C_ST;
    else if (op >= OP_ALU_FIRST && op <= OP_ALU_LAST)   c = C_RTYPE;
    else if (op == OP_BEQ)                              c = C_BEQ;
    else if (op == OP_BNE)                              c = C_BNE;
    else if (op == OP_JMP)                              c = C_JMP;
    else                                                c = C_ILLEGAL;
    return c;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts consecutive cycles a memory request is pending
// without mem_ready and flags the cycle on which the bound is reached.
//   clk      in  clock
//   reset    in  synchronous, active-high
//   req      in  a read or write request is outstanding this cycle
//   ready    in  memory completes the request this cycle
//   timeout  out this is the MEM_TIMEOUT-th consecutive stalled cycle
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic ready,
  output logic timeout
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt_reg;

  // The counter holds the number of stalled cycles already seen, so the
  // current cycle is the last one allowed when it equals MEM_TIMEOUT-1.
  assign timeout = req & ~ready & (wait_cnt_reg == CNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || !req || ready || timeout) begin
      wait_cnt_reg <= '0;
    end else begin
      wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: multi-cycle control sequencer for the 16-bit RISC
// datapath. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB over a
// single shared memory port.
//   clk, reset        clock; synchronous active-high reset
//   op_code[3:0]      IR[15:12], looked at only in DECODE
//   mem_ready         memory completes the current access this cycle
//   alu_zero          ALU zero flag, used in EXEC for branches
//   ir_write/pc_write IR latch and PC update strobes
//   jump/beq/bne      PC source selects
//   mem_read/write    memory request (fetch or LD / ST)
//   alu_src, reg_dst, mem_to_reg, reg_write, alu_op[1:0]  datapath controls
//   bus_err           sticky: a memory access stalled for MEM_TIMEOUT cycles
//   illegal_op        one-cycle pulse in DECODE on an undefined opcode
//   retired           completed-instruction count, wraps
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int RETIRE_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          op_code,
  input  logic                mem_ready,
  input  logic                alu_zero,
  output logic                ir_write,
  output logic                pc_write,
  output logic                jump,
  output logic                beq,
  output logic                bne,
  output logic                mem_read,
  output logic                mem_write,
  output logic                alu_src,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic [1:0]          alu_op,
  output logic                bus_err,
  output logic                illegal_op,
  output logic [RETIRE_W-1:0] retired
);

  import risc16_pkg::*;

  state_t              state_reg;
  op_class_t           cls_reg;
  op_class_t           dec_class;
  logic                mem_read_reg, mem_write_reg, alu_src_reg, reg_dst_reg;
  logic                mem_to_reg_reg, reg_write_reg;
  logic                jump_reg, beq_reg, bne_reg, bus_err_reg;
  logic [1:0]          alu_op_reg;
  logic [RETIRE_W-1:0] retired_reg;
  logic                mem_req, mem_done, timeout, retire;

  assign dec_class = classify(op_code);

  // Requests are only ever raised in FETCH/MEM, so mem_ready elsewhere is
  // ignored. The cycle right after reset has no request yet (all outputs
  // come out of reset low), so nothing completes in it.
  assign mem_req  = mem_read_reg | mem_write_reg;
  assign mem_done = mem_req & mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .req    (mem_req),
    .ready  (mem_ready),
    .timeout(timeout)
  );

  always_comb begin
    retire = 1'b0;
    case (state_reg)
      S_EXEC:  retire = (cls_reg == C_BEQ) || (cls_reg == C_BNE) || (cls_reg == C_JMP);
      S_MEM:   retire = (cls_reg == C_ST) && mem_done;
      S_WB:    retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  // Moore controls are registered: each transition loads the control set of
  // the state being entered, so they are valid for the whole state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_FETCH;
      cls_reg        <= C_ILLEGAL;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      alu_src_reg    <= 1'b0;
      reg_dst_reg    <= 1'b0;
      mem_to_reg_reg <= 1'b0;
      reg_write_reg  <= 1'b0;
      jump_reg       <= 1'b0;
      beq_reg        <= 1'b0;
      bne_reg        <= 1'b0;
      alu_op_reg     <= ALU_OP_ADD;
      bus_err_reg    <= 1'b0;
      retired_reg    <= '0;
    end else begin
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      alu_src_reg    <= 1'b0;
      reg_dst_reg    <= 1'b0;
      mem_to_reg_reg <= 1'b0;
      reg_write_reg  <= 1'b0;
      jump_reg       <= 1'b0;
      beq_reg        <= 1'b0;
      bne_reg        <= 1'b0;
      alu_op_reg     <= ALU_OP_ADD;

      if (timeout) bus_err_reg <= 1'b1;
      if (retire)  retired_reg <= retired_reg + RETIRE_W'(1);

      case (state_reg)
        S_FETCH: begin
          if (mem_done) begin
            state_reg <= S_DECODE;
          end else begin
            // Stall, or timeout: a timed-out fetch is simply retried.
            state_reg    <= S_FETCH;
            mem_read_reg <= 1'b1;
          end
        end

        S_DECODE: begin
          cls_reg <= dec_class;
          case (dec_class)
            C_RTYPE: begin
              state_reg  <= S_EXEC;
              alu_op_reg <= ALU_OP_FUNCT;
            end
            C_LD, C_ST: begin
              state_reg   <= S_EXEC;
              alu_src_reg <= 1'b1;
            end
            C_BEQ: begin
              state_reg  <= S_EXEC;
              alu_op_reg <= ALU_OP_SUB;
              beq_reg    <= 1'b1;
            end
            C_BNE: begin
              state_reg  <= S_EXEC;
              alu_op_reg <= ALU_OP_SUB;
              bne_reg    <= 1'b1;
            end
            C_JMP: begin
              state_reg <= S_EXEC;
              jump_reg  <= 1'b1;
            end
            default: begin
              state_reg    <= S_FETCH;
              mem_read_reg <= 1'b1;
            end
          endcase
        end

        S_EXEC: begin
          case (cls_reg)
            C_RTYPE: begin
              state_reg     <= S_WB;
              reg_write_reg <= 1'b1;
              reg_dst_reg   <= 1'b1;
            end
            C_LD: begin
              state_reg    <= S_MEM;
              mem_read_reg <= 1'b1;
            end
            C_ST: begin
              state_reg     <= S_MEM;
              mem_write_reg <= 1'b1;
            end
            default: begin
              state_reg    <= S_FETCH;
              mem_read_reg <= 1'b1;
            end
          endcase
        end

        S_MEM: begin
          if (timeout) begin
            state_reg    <= S_FETCH;
            mem_read_reg <= 1'b1;
          end else if (mem_done) begin
            if (cls_reg == C_LD) begin
              state_reg      <= S_WB;
              reg_write_reg  <= 1'b1;
              mem_to_reg_reg <= 1'b1;
            end else begin
              state_reg    <= S_FETCH;
              mem_read_reg <= 1'b1;
            end
          end else begin
            state_reg     <= S_MEM;
            mem_read_reg  <= (cls_reg == C_LD);
            mem_write_reg <= (cls_reg == C_ST);
          end
        end

        default: begin
          state_reg    <= S_FETCH;
          mem_read_reg <= 1'b1;
        end
      endcase
    end
  end

  // Handshake- and flag-dependent strobes have to act in the same cycle as
  // mem_ready / alu_zero / op_code, so they are qualified combinationally.
  assign ir_write   = (state_reg == S_FETCH) & mem_done;
  assign pc_write   = ir_write | jump_reg | (beq_reg & alu_zero) | (bne_reg & ~alu_zero);
  assign illegal_op = (state_reg == S_DECODE) & (dec_class == C_ILLEGAL);

  assign jump       = jump_reg;
  assign beq        = beq_reg;
  assign bne        = bne_reg;
  assign mem_read   = mem_read_reg;
  assign mem_write  = mem_write_reg;
  assign alu_src    = alu_src_reg;
  assign reg_dst    = reg_dst_reg;
  assign mem_to_reg = mem_to_reg_reg;
  assign reg_write  = reg_write_reg;
  assign alu_op     = alu_op_reg;
  assign bus_err    = bus_err_reg;
  assign retired    = retired_reg;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm. Each instruction is expanded
// into the sequence of phases it must pass through (from its class, the
// number of stalled memory cycles and the timeout bound); a table maps each
// phase to the required control outputs. A negedge process compares every
// cycle, and literal checks pin the individual scenarios.
module tb_multicycle_ctrl_fsm;

  localparam int TMO = 16;

  localparam int K_LD = 0, K_ST = 1, K_R = 2, K_BEQ = 3, K_BNE = 4, K_JMP = 5, K_ILL = 6;

  typedef enum int {P_IDLE, P_FETCH, P_DECODE, P_EXEC, P_MEM, P_WB} phase_e;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       jump;
    logic       beq;
    logic       bne;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_op;
    logic       bus_err;
    logic       illegal_op;
  } outs_t;

  logic        clk;
  logic        reset;
  logic [3:0]  op_code;
  logic        mem_ready;
  logic        alu_zero;
  logic        ir_write, pc_write, jump, beq, bne, mem_read, mem_write;
  logic        alu_src, reg_dst, mem_to_reg, reg_write, bus_err, illegal_op;
  logic [1:0]  alu_op;
  logic [15:0] retired;

  multicycle_ctrl_fsm #(
    .MEM_TIMEOUT(TMO),
    .RETIRE_W   (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .op_code   (op_code),
    .mem_ready (mem_ready),
    .alu_zero  (alu_zero),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .jump      (jump),
    .beq       (beq),
    .bne       (bne),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .alu_src   (alu_src),
    .reg_dst   (reg_dst),
    .mem_to_reg(mem_to_reg),
    .reg_write (reg_write),
    .alu_op    (alu_op),
    .bus_err   (bus_err),
    .illegal_op(illegal_op),
    .retired   (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  outs_t       dut_outs;
  assign dut_outs = {ir_write, pc_write, jump, beq, bne, mem_read, mem_write,
                     alu_src, reg_dst, mem_to_reg, reg_write, alu_op, bus_err, illegal_op};

  int          n_tests = 0;
  int          n_fail  = 0;
  logic        chk_en  = 1'b0;
  outs_t       exp_outs;
  logic [15:0] exp_ret = 16'd0;
  logic        exp_bus_err = 1'b0;
  string       cur_name = "init";
  outs_t       tr[$];
  logic [15:0] tr_ret[$];

  function automatic int kind_of(input logic [3:0] op);
    case (op)
      4'h0:                                     return K_LD;
      4'h1:                                     return K_ST;
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: return K_R;
      4'hB:                                     return K_BEQ;
      4'hC:                                     return K_BNE;
      4'hD:                                     return K_JMP;
      default:                                  return K_ILL;
    endcase
  endfunction

  // Required outputs for one cycle spent in a given phase.
  function automatic outs_t expect_outs(input phase_e ph, input int k, input logic rdy, input logic z);
    outs_t e;
    e = '0;
    case (ph)
      P_FETCH: begin
        e.mem_read = 1'b1;
        e.ir_write = rdy;
        e.pc_write = rdy;
      end
      P_DECODE: e.illegal_op = (k == K_ILL);
      P_EXEC: begin
        if (k == K_R) e.alu_op = 2'b10;
        if (k == K_LD || k == K_ST) e.alu_src = 1'b1;
        if (k == K_BEQ) begin e.alu_op = 2'b01; e.beq = 1'b1; e.pc_write = z;  end
        if (k == K_BNE) begin e.alu_op = 2'b01; e.bne = 1'b1; e.pc_write = ~z; end
        if (k == K_JMP) begin e.jump = 1'b1; e.pc_write = 1'b1; end
      end
      P_MEM: begin
        e.mem_read  = (k == K_LD);
        e.mem_write = (k == K_ST);
      end
      P_WB: begin
        e.reg_write  = 1'b1;
        e.reg_dst    = (k == K_R);
        e.mem_to_reg = (k == K_LD);
      end
      default: e = '0;
    endcase
    e.bus_err = exp_bus_err;
    return e;
  endfunction

  function automatic logic [3:0] rnd4();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if (dut_outs !== exp_outs) begin
        n_fail++;
        $display("FAIL outputs[%s] t=%0t actual=%b required=%b", cur_name, $time, dut_outs, exp_outs);
      end
      n_tests++;
      if (retired !== exp_ret) begin
        n_fail++;
        $display("FAIL retired[%s] t=%0t actual=%0d required=%0d", cur_name, $time, retired, exp_ret);
      end
    end
  end

  task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic cyc(input logic rst, input logic [3:0] op, input logic rdy, input logic z,
                     input outs_t e, input string nm);
    reset     = rst;
    op_code   = op;
    mem_ready = rdy;
    alu_zero  = z;
    exp_outs  = e;
    cur_name  = nm;
    chk_en    = 1'b1;
    #1;
    tr.push_back(dut_outs);
    tr_ret.push_back(retired);
    @(posedge clk);
    #1;
  endtask

  task automatic ph(input phase_e p, input int k, input logic [3:0] op, input logic rdy,
                    input logic z, input string nm);
    cyc(1'b0, op, rdy, z, expect_outs(p, k, rdy, z), nm);
  endtask

  task automatic reset_seq(input outs_t first_e, input int n, input string nm);
    cyc(1'b1, rnd4(), 1'b0, 1'b0, first_e, nm);
    exp_ret     = 16'd0;
    exp_bus_err = 1'b0;
    for (int i = 1; i < n; i++) cyc(1'b1, rnd4(), rnd1(), rnd1(), '0, nm);
    cyc(1'b0, rnd4(), rnd1(), rnd1(), '0, nm);
  endtask

  task automatic run_instr(input logic [3:0] op, input int fwait, input int mwait,
                           input logic z, input string nm);
    int k;
    k = kind_of(op);
    tr.delete();
    tr_ret.delete();
    for (int i = 0; i < fwait && i < TMO; i++) ph(P_FETCH, k, rnd4(), 1'b0, rnd1(), nm);
    if (fwait >= TMO) begin
      exp_bus_err = 1'b1;
      return;
    end
    ph(P_FETCH, k, rnd4(), 1'b1, rnd1(), nm);
    ph(P_DECODE, k, op, rnd1(), rnd1(), nm);
    if (k == K_ILL) return;
    ph(P_EXEC, k, rnd4(), rnd1(), z, nm);
    if (k == K_BEQ || k == K_BNE || k == K_JMP) begin
      exp_ret++;
      return;
    end
    if (k == K_LD || k == K_ST) begin
      for (int i = 0; i < mwait && i < TMO; i++) ph(P_MEM, k, rnd4(), 1'b0, rnd1(), nm);
      if (mwait >= TMO) begin
        exp_bus_err = 1'b1;
        return;
      end
      ph(P_MEM, k, rnd4(), 1'b1, rnd1(), nm);
      if (k == K_ST) begin
        exp_ret++;
        return;
      end
    end
    ph(P_WB, k, rnd4(), rnd1(), rnd1(), nm);
    exp_ret++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    op_code   = 4'h0;
    mem_ready = 1'b0;
    alu_zero  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_seq('0, 2, "power_on_reset");

    // Reset held 3 cycles while an ST is stalled in MEM.
    run_instr(4'h2, 0, 0, 1'b0, "add_before_reset");
    tr.delete();
    tr_ret.delete();
    ph(P_FETCH,  K_ST, rnd4(), 1'b1, 1'b0, "st_reset");
    ph(P_DECODE, K_ST, 4'h1,   1'b0, 1'b0, "st_reset");
    ph(P_EXEC,   K_ST, rnd4(), 1'b0, 1'b0, "st_reset");
    ph(P_MEM,    K_ST, rnd4(), 1'b0, 1'b0, "st_reset");
    ph(P_MEM,    K_ST, rnd4(), 1'b0, 1'b0, "st_reset");
    reset_seq(expect_outs(P_MEM, K_ST, 1'b0, 1'b0), 3, "st_reset");
    pin("rst_mem_write_in_reset_cycle", 32'(tr[5].mem_write), 32'd1);
    pin("rst_retired_before",           32'(tr_ret[5]),        32'd1);
    pin("rst_mem_write_after",          32'(tr[6].mem_write), 32'd0);
    pin("rst_mem_read_after",           32'(tr[6].mem_read),  32'd0);
    pin("rst_retired_after",            32'(tr_ret[6]),        32'd0);
    pin("rst_idle_mem_read",            32'(tr[8].mem_read),  32'd0);

    // ADD with zero wait states.
    run_instr(4'h2, 0, 0, 1'b0, "add");
    pin("add_ir_write_c1",   32'(tr[0].ir_write),  32'd1);
    pin("add_reg_write_c4",  32'(tr[3].reg_write), 32'd1);
    pin("add_reg_dst_c4",    32'(tr[3].reg_dst),   32'd1);
    pin("add_alu_op_c3",     32'(tr[2].alu_op),    32'd2);
    pin("add_retired",       32'(retired),         32'd1);

    // LD with 3 stalled MEM cycles: WB is the 8th cycle.
    run_instr(4'h0, 0, 3, 1'b0, "ld_wait3");
    pin("ld_mem_read_c7",    32'(tr[6].mem_read),   32'd1);
    pin("ld_mem_to_reg_c8",  32'(tr[7].mem_to_reg), 32'd1);
    pin("ld_reg_write_c8",   32'(tr[7].reg_write),  32'd1);
    pin("ld_bus_err",        32'(bus_err),          32'd0);
    pin("ld_retired",        32'(retired),          32'd2);

    // Branches and jump.
    run_instr(4'hB, 0, 0, 1'b1, "beq_taken");
    pin("beq_z1_pc_write",   32'(tr[2].pc_write), 32'd1);
    pin("beq_z1_retired",    32'(retired),        32'd3);
    run_instr(4'hB, 0, 0, 1'b0, "beq_not_taken");
    pin("beq_z0_pc_write",   32'(tr[2].pc_write), 32'd0);
    pin("beq_z0_beq",        32'(tr[2].beq),      32'd1);
    pin("beq_z0_retired",    32'(retired),        32'd4);
    run_instr(4'hC, 0, 0, 1'b0, "bne_taken");
    pin("bne_z0_pc_write",   32'(tr[2].pc_write), 32'd1);
    run_instr(4'hD, 1, 0, 1'b0, "jmp");
    pin("jmp_jump",          32'(tr[3].jump),     32'd1);
    pin("jmp_retired",       32'(retired),        32'd6);

    // Undefined opcodes.
    run_instr(4'hF, 0, 0, 1'b0, "illegal_f");
    pin("ill_f_pulse",       32'(tr[1].illegal_op), 32'd1);
    pin("ill_f_retired",     32'(retired),          32'd6);
    pin("ill_f_back_fetch",  32'(mem_read),         32'd1);
    run_instr(4'hA, 0, 0, 1'b0, "illegal_a");
    pin("ill_a_pulse",       32'(tr[1].illegal_op), 32'd1);
    run_instr(4'hE, 2, 0, 1'b0, "illegal_e");

    // ST with stalls on both the fetch and the data access, then R-types.
    run_instr(4'h1, 2, 1, 1'b0, "st_waits");
    pin("st_retired",        32'(retired), 32'd7);
    run_instr(4'h9, 3, 0, 1'b1, "alu_9");
    run_instr(4'h5, 0, 0, 1'b0, "alu_5");

    // Fetch stuck: bus_err after the 16th stalled cycle, retry from FETCH.
    run_instr(4'h3, TMO, 0, 1'b0, "fetch_timeout");
    pin("fto_bus_err_c16",   32'(tr[15].bus_err),  32'd0);
    pin("fto_bus_err_after", 32'(bus_err),         32'd1);
    pin("fto_mem_read",      32'(mem_read),        32'd1);
    pin("fto_retired",       32'(retired),         32'd9);
    run_instr(4'h2, 0, 0, 1'b0, "add_after_fto");
    pin("fto_bus_err_sticky", 32'(tr[3].bus_err),  32'd1);
    pin("fto_add_retired",   32'(retired),         32'd10);

    // Reset clears bus_err; then a LD whose data access times out.
    reset_seq(expect_outs(P_FETCH, K_R, 1'b0, 1'b0), 2, "reset2");
    pin("rst2_bus_err",      32'(bus_err), 32'd0);
    run_instr(4'h0, 0, TMO, 1'b0, "ld_mem_timeout");
    pin("mto_bus_err_c19",   32'(tr[18].bus_err), 32'd0);
    pin("mto_bus_err_after", 32'(bus_err),        32'd1);
    pin("mto_mem_read",      32'(mem_read),       32'd1);
    pin("mto_mem_write",     32'(mem_write),      32'd0);
    pin("mto_retired",       32'(retired),        32'd0);
    run_instr(4'h1, 0, 0, 1'b0, "st_after_mto");
    pin("mto_st_retired",    32'(retired),        32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
